// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32 pipeline: word-organised RAM with byte-lane stores,
// extended loads with one cycle of latency, a post-reset zeroing sweep and a sticky misalign error.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic        clock,
  input  logic        clr_n,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemdatain,
  input  logic [2:0]  dmemop,
  input  logic        dmemwe,
  input  logic        dmemre,
  input  logic        err_clr,
  output logic [31:0] dmemdataout,
  output logic        ready,
  output logic        misalign_err,
  output logic [31:0] err_addr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic {INIT, READY} state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   cnt, next_cnt;
  logic                    sweep_we;

  logic [31:0]             mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   idx;
  logic [1:0]              off;
  logic                    acc_st, acc_ld;
  logic                    st_legal, ld_legal;
  logic                    illegal;
  logic [3:0]              be;
  logic [31:0]             wdata;

  // Upper address bits alias away by design.
  logic unused_addr;
  assign unused_addr = ^dmemaddr[31:ADDR_WIDTH+2];

  assign idx = dmemaddr[ADDR_WIDTH+1:2];
  assign off = dmemaddr[1:0];

  // NOTE: state register is sequential, so it uses non-blocking assignments only.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    ready      = 1'b0;
    sweep_we   = 1'b0;
    case (state)
      INIT: begin
        if (INIT_ZERO) begin
          sweep_we = 1'b1;
          next_cnt = cnt + 1'b1;
          if (cnt == ADDR_WIDTH'(DEPTH - 1)) next_state = READY;
        end else begin
          next_state = READY;
        end
      end
      READY: ready = 1'b1;
      default: next_state = INIT;
    endcase
  end

  assign acc_st = ready & dmemwe;
  assign acc_ld = ready & dmemre & ~dmemwe;

  always_comb begin
    st_legal = 1'b0;
    ld_legal = 1'b0;
    be       = 4'b0000;
    wdata    = dmemdatain;
    case (dmemop)
      OP_B: begin
        st_legal = 1'b1;
        ld_legal = 1'b1;
        be       = 4'b0001 << off;
        wdata    = {4{dmemdatain[7:0]}};
      end
      OP_H: begin
        st_legal = ~off[0];
        ld_legal = ~off[0];
        be       = 4'b0011 << off;
        wdata    = {2{dmemdatain[15:0]}};
      end
      OP_W: begin
        st_legal = (off == 2'd0);
        ld_legal = (off == 2'd0);
        be       = 4'b1111;
      end
      OP_BU:   ld_legal = 1'b1;
      OP_HU:   ld_legal = ~off[0];
      default: ;
    endcase
  end

  assign illegal = (acc_st & ~st_legal) | (acc_ld & ~ld_legal);

  // NOTE: RAM array has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clock) begin
    if (sweep_we) begin
      mem[cnt] <= '0;
    end else if (acc_st && st_legal) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  function automatic logic [31:0] extend(input logic [31:0] word,
                                         input logic [1:0]  o,
                                         input logic [2:0]  op);
    logic [31:0] sh;
    sh = word >> {o, 3'b000};
    case (op)
      OP_B:    return {{24{sh[7]}}, sh[7:0]};
      OP_BU:   return {24'h0, sh[7:0]};
      OP_H:    return {{16{sh[15]}}, sh[15:0]};
      OP_HU:   return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      dmemdataout <= '0;
    end else if (acc_ld && ld_legal) begin
      dmemdataout <= extend(mem[idx], off, dmemop);
    end
  end

  // A new error outranks err_clr on the same edge and re-captures the address.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else if (illegal && (!misalign_err || err_clr)) begin
      misalign_err <= 1'b1;
      err_addr     <= dmemaddr;
    end else if (err_clr) begin
      misalign_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: sweep timing, load extension, byte lanes,
// misalignment error capture, reset mid-sweep, aliasing and store/load collision.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        clr_n;
  logic [31:0] dmemaddr;
  logic [31:0] dmemdatain;
  logic [2:0]  dmemop;
  logic        dmemwe;
  logic        dmemre;
  logic        err_clr;
  logic [31:0] dmemdataout;
  logic        ready;
  logic        misalign_err;
  logic [31:0] err_addr;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.ADDR_WIDTH(10), .INIT_ZERO(1'b1)) dut (
    .clock        (clock),
    .clr_n        (clr_n),
    .dmemaddr     (dmemaddr),
    .dmemdatain   (dmemdatain),
    .dmemop       (dmemop),
    .dmemwe       (dmemwe),
    .dmemre       (dmemre),
    .err_clr      (err_clr),
    .dmemdataout  (dmemdataout),
    .ready        (ready),
    .misalign_err (misalign_err),
    .err_addr     (err_addr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dmemwe  = 1'b0;
    dmemre  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    dmemaddr = a; dmemdatain = d; dmemop = op; dmemwe = 1'b1; dmemre = 1'b0;
    tick();
    idle();
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] op);
    dmemaddr = a; dmemop = op; dmemre = 1'b1; dmemwe = 1'b0;
    tick();
    idle();
  endtask

  // Counts edges after release until ready rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 2000) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    clr_n = 1'b0; dmemaddr = '0; dmemdatain = '0; dmemop = 3'b010;
    idle();
    #1;
    check("rst_dataout", dmemdataout, 32'h0);
    check("rst_ready",   {31'h0, ready}, 32'h0);
    check("rst_err",     {31'h0, misalign_err}, 32'h0);
    check("rst_erraddr", err_addr, 32'h0);
    tick(); tick();
    clr_n = 1'b1;

    wait_ready(n);
    check("sweep_len", n, 1024);
    load(32'h14, 3'b010);
    check("lw_0x14_zero", dmemdataout, 32'h0);

    // Load extension
    store(32'h10, 32'hDEADBEEF, 3'b010);
    load(32'h13, 3'b000);
    check("lb_0x13", dmemdataout, 32'hFFFFFFDE);
    load(32'h13, 3'b100);
    check("lbu_0x13", dmemdataout, 32'h000000DE);
    load(32'h12, 3'b001);
    check("lh_0x12", dmemdataout, 32'hFFFFDEAD);
    load(32'h10, 3'b101);
    check("lhu_0x10", dmemdataout, 32'h0000BEEF);
    load(32'h11, 3'b000);
    check("lb_0x11", dmemdataout, 32'hFFFFFFBE);

    // Byte lanes
    store(32'h11, 32'hFFFFFF5A, 3'b000);
    load(32'h10, 3'b010);
    check("sb_lane1", dmemdataout, 32'hDEAD5AEF);
    store(32'h12, 32'hABCD1234, 3'b001);
    load(32'h10, 3'b010);
    check("sh_upper", dmemdataout, 32'h12345AEF);
    check("no_err_yet", {31'h0, misalign_err}, 32'h0);

    // Misalignment
    store(32'h22, 32'h1, 3'b010);
    check("sw_mis_err", {31'h0, misalign_err}, 32'h1);
    check("sw_mis_addr", err_addr, 32'h22);
    load(32'h20, 3'b010);
    check("sw_mis_nowrite", dmemdataout, 32'h0);
    load(32'h10, 3'b010);
    check("lw_reload", dmemdataout, 32'h12345AEF);
    load(32'h31, 3'b001);
    check("lh_mis_hold", dmemdataout, 32'h12345AEF);
    check("lh_mis_firstwins", err_addr, 32'h22);
    check("lh_mis_flag", {31'h0, misalign_err}, 32'h1);

    err_clr = 1'b1;
    tick();
    idle();
    check("errclr_alone", {31'h0, misalign_err}, 32'h0);
    check("errclr_addr_kept", err_addr, 32'h22);

    dmemaddr = 32'h40; dmemop = 3'b110; dmemre = 1'b1; err_clr = 1'b1;
    tick();
    idle();
    check("errclr_vs_err_flag", {31'h0, misalign_err}, 32'h1);
    check("errclr_vs_err_addr", err_addr, 32'h40);
    check("illegal_op_hold", dmemdataout, 32'h12345AEF);

    // Aliasing and collision
    store(32'h1000, 32'hCAFEF00D, 3'b010);
    load(32'h0, 3'b010);
    check("alias_lw", dmemdataout, 32'hCAFEF00D);
    dmemaddr = 32'h4; dmemdatain = 32'h11112222; dmemop = 3'b010;
    dmemwe = 1'b1; dmemre = 1'b1;
    tick();
    idle();
    check("collide_hold", dmemdataout, 32'hCAFEF00D);
    load(32'h4, 3'b010);
    check("collide_written", dmemdataout, 32'h11112222);

    // Reset in READY, then again mid-sweep
    clr_n = 1'b0;
    #1;
    check("rst2_dataout", dmemdataout, 32'h0);
    check("rst2_ready",   {31'h0, ready}, 32'h0);
    check("rst2_err",     {31'h0, misalign_err}, 32'h0);
    check("rst2_erraddr", err_addr, 32'h0);
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 100) begin
        dmemaddr = 32'h22; dmemop = 3'b010; dmemwe = 1'b1;
      end else begin
        idle();
      end
      tick();
    end
    idle();
    check("init_ignores_req", {31'h0, misalign_err}, 32'h0);
    check("mid_sweep_ready", {31'h0, ready}, 32'h0);
    clr_n = 1'b0;
    #1;
    check("rst3_ready", {31'h0, ready}, 32'h0);
    check("rst3_dataout", dmemdataout, 32'h0);
    tick();
    clr_n = 1'b1;
    wait_ready(n);
    check("resweep_len", n, 1024);
    load(32'h0, 3'b010);
    check("sweep_cleared", dmemdataout, 32'h0);
    load(32'h4, 3'b010);
    check("sweep_cleared_w1", dmemdataout, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
